// File: rtl/alu_issue_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_iq_pkg : shared types, opcodes and age helper for the ALU IQ     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_iq_pkg;

    localparam int SIZE       = 32;
    localparam int REG_NUM    = 64;
    localparam int TW         = $clog2(REG_NUM);
    localparam int ALUOP_BITS = 3;
    localparam int ROB_ROWS   = 16;
    localparam int RW         = $clog2(ROB_ROWS);

    localparam logic [ALUOP_BITS-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_BITS-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_BITS-1:0] ALU_AND = 3'd2;
    localparam logic [ALUOP_BITS-1:0] ALU_XOR = 3'd3;
    localparam logic [ALUOP_BITS-1:0] ALU_SRA = 3'd4;

    typedef struct packed {
        logic                  valid;
        logic [ALUOP_BITS-1:0] aluop;
        logic [TW-1:0]         src1;
        logic [TW-1:0]         src2;
        logic                  rdy1;
        logic                  rdy2;
        logic                  use_imm;
        logic [SIZE-1:0]       imm;
        logic [TW-1:0]         dest;
        logic [RW-1:0]         robn;
    } iq_entry_t;

    // Distance from the ROB head; modular subtraction handles wraparound.
    function automatic logic [RW-1:0] rob_age(input logic [RW-1:0] robn,
                                              input logic [RW-1:0] head);
        return robn - head;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_queue_if : dispatch / wakeup / flush / FU issue bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_issue_queue_if
    import alu_iq_pkg::*;
#(
    parameter int NUM_WB   = 2,
    parameter int IQ_DEPTH = 8
);
    localparam int CW = $clog2(IQ_DEPTH + 1);

    logic                            disp_valid;
    logic                            disp_ready;
    logic [ALUOP_BITS-1:0]           disp_aluop;
    logic [TW-1:0]                   disp_src1;
    logic [TW-1:0]                   disp_src2;
    logic                            disp_src1_rdy;
    logic                            disp_src2_rdy;
    logic                            disp_use_imm;
    logic [SIZE-1:0]                 disp_imm;
    logic [TW-1:0]                   disp_dest;
    logic [RW-1:0]                   disp_robn;
    logic [RW-1:0]                   rob_head;
    logic [NUM_WB-1:0]               wb_valid;
    logic [NUM_WB-1:0][TW-1:0]       wb_reg;
    logic                            flush;
    logic                            fu_ready;
    logic                            iss_valid;
    logic [ALUOP_BITS-1:0]           iss_aluop;
    logic [TW-1:0]                   iss_src1;
    logic [TW-1:0]                   iss_src2;
    logic                            iss_use_imm;
    logic [SIZE-1:0]                 iss_imm;
    logic [TW-1:0]                   iss_dest;
    logic [RW-1:0]                   iss_robn;
    logic [CW-1:0]                   count;

    modport master (
        output disp_valid, disp_aluop, disp_src1, disp_src2, disp_src1_rdy,
               disp_src2_rdy, disp_use_imm, disp_imm, disp_dest, disp_robn,
               rob_head, wb_valid, wb_reg, flush, fu_ready,
        input  disp_ready, iss_valid, iss_aluop, iss_src1, iss_src2,
               iss_use_imm, iss_imm, iss_dest, iss_robn, count
    );

    modport slave (
        input  disp_valid, disp_aluop, disp_src1, disp_src2, disp_src1_rdy,
               disp_src2_rdy, disp_use_imm, disp_imm, disp_dest, disp_robn,
               rob_head, wb_valid, wb_reg, flush, fu_ready,
        output disp_ready, iss_valid, iss_aluop, iss_src1, iss_src2,
               iss_use_imm, iss_imm, iss_dest, iss_robn, count
    );

endinterface
`default_nettype wire

// File: rtl/alu_issue_queue_age_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_age_select : combinational oldest-ready picker (lower idx on tie) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iq_age_select #(
    parameter int DEPTH = 8,
    parameter int RW    = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  wire logic [DEPTH-1:0]         cand_i,
    input  wire logic [DEPTH-1:0][RW-1:0] age_i,
    output logic      [IW-1:0]            grant_o,
    output logic                          found_o
);

    logic [RW-1:0] best_age;

    // Strict less-than keeps the earlier (lower-index) entry on equal age.
    always_comb begin
        grant_o  = '0;
        found_o  = 1'b0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand_i[i] && (!found_o || (age_i[i] < best_age))) begin
                grant_o  = IW'(i);
                found_o  = 1'b1;
                best_age = age_i[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_queue : reservation station feeding one single-cycle ALU   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int IQ_DEPTH = 8,
    parameter int NUM_WB   = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_issue_queue_if.slave   io
);

    localparam int CW = $clog2(IQ_DEPTH + 1);
    localparam int IW = $clog2(IQ_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

    iq_entry_t [IQ_DEPTH-1:0]   entries_q, entries_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       iss_valid_q, iss_valid_d;
    logic [ALUOP_BITS-1:0]      iss_aluop_q, iss_aluop_d;
    logic [TW-1:0]              iss_src1_q, iss_src1_d;
    logic [TW-1:0]              iss_src2_q, iss_src2_d;
    logic                       iss_use_imm_q, iss_use_imm_d;
    logic [SIZE-1:0]            iss_imm_q, iss_imm_d;
    logic [TW-1:0]              iss_dest_q, iss_dest_d;
    logic [RW-1:0]              iss_robn_q, iss_robn_d;

    logic [IQ_DEPTH-1:0]         cand;
    logic [IQ_DEPTH-1:0][RW-1:0] age;
    logic [IW-1:0]               grant;
    logic                        found;
    logic [IW-1:0]               free_idx;
    logic                        disp_ready;
    logic                        accept;
    logic                        issue;
    iq_entry_t                   sel;

    // A tag wakes on any broadcast port or on the destination being issued now.
    function automatic logic wake(input logic [NUM_WB-1:0]         v,
                                  input logic [NUM_WB-1:0][TW-1:0] r,
                                  input logic                      self_v,
                                  input logic [TW-1:0]             self_tag,
                                  input logic [TW-1:0]             tag);
        logic hit;
        hit = self_v && (self_tag == tag);
        for (int k = 0; k < NUM_WB; k++) begin
            hit = hit | (v[k] && (r[k] == tag));
        end
        return hit;
    endfunction

    generate
        for (genvar g = 0; g < IQ_DEPTH; g++) begin : g_cand
            assign cand[g] = entries_q[g].valid && entries_q[g].rdy1 && entries_q[g].rdy2;
            assign age[g]  = rob_age(entries_q[g].robn, io.rob_head);
        end
    endgenerate

    iq_age_select #(
        .DEPTH (IQ_DEPTH),
        .RW    (RW),
        .IW    (IW)
    ) u_select (
        .cand_i  (cand),
        .age_i   (age),
        .grant_o (grant),
        .found_o (found)
    );

    always_comb begin
        free_idx = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) free_idx = IW'(i);
        end
    end

    assign disp_ready = (count_q < DEPTH_C);
    assign accept     = io.disp_valid && disp_ready;
    assign issue      = io.fu_ready && found;
    assign sel        = entries_q[grant];

    always_comb begin
        entries_d     = entries_q;
        count_d       = count_q;
        iss_valid_d   = 1'b0;
        iss_aluop_d   = iss_aluop_q;
        iss_src1_d    = iss_src1_q;
        iss_src2_d    = iss_src2_q;
        iss_use_imm_d = iss_use_imm_q;
        iss_imm_d     = iss_imm_q;
        iss_dest_d    = iss_dest_q;
        iss_robn_d    = iss_robn_q;

        if (io.flush) begin
            for (int i = 0; i < IQ_DEPTH; i++) entries_d[i].valid = 1'b0;
            count_d = '0;
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (entries_q[i].valid) begin
                    if (wake(io.wb_valid, io.wb_reg, issue, sel.dest, entries_q[i].src1))
                        entries_d[i].rdy1 = 1'b1;
                    if (wake(io.wb_valid, io.wb_reg, issue, sel.dest, entries_q[i].src2))
                        entries_d[i].rdy2 = 1'b1;
                    if (issue && (grant == IW'(i)))
                        entries_d[i].valid = 1'b0;
                end
            end

            // The free slot is still invalid, so the wakeup loop never touched it.
            if (accept) begin
                entries_d[free_idx].valid   = 1'b1;
                entries_d[free_idx].aluop   = io.disp_aluop;
                entries_d[free_idx].src1    = io.disp_src1;
                entries_d[free_idx].src2    = io.disp_src2;
                entries_d[free_idx].rdy1    = io.disp_src1_rdy
                    | wake(io.wb_valid, io.wb_reg, issue, sel.dest, io.disp_src1);
                entries_d[free_idx].rdy2    = io.disp_use_imm | io.disp_src2_rdy
                    | wake(io.wb_valid, io.wb_reg, issue, sel.dest, io.disp_src2);
                entries_d[free_idx].use_imm = io.disp_use_imm;
                entries_d[free_idx].imm     = io.disp_imm;
                entries_d[free_idx].dest    = io.disp_dest;
                entries_d[free_idx].robn    = io.disp_robn;
            end

            if (issue) begin
                iss_valid_d   = 1'b1;
                iss_aluop_d   = sel.aluop;
                iss_src1_d    = sel.src1;
                iss_src2_d    = sel.src2;
                iss_use_imm_d = sel.use_imm;
                iss_imm_d     = sel.imm;
                iss_dest_d    = sel.dest;
                iss_robn_d    = sel.robn;
            end

            count_d = count_q + CW'(accept) - CW'(issue);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IQ_DEPTH; i++) entries_q[i] <= '0;
            count_q       <= '0;
            iss_valid_q   <= 1'b0;
            iss_aluop_q   <= '0;
            iss_src1_q    <= '0;
            iss_src2_q    <= '0;
            iss_use_imm_q <= 1'b0;
            iss_imm_q     <= '0;
            iss_dest_q    <= '0;
            iss_robn_q    <= '0;
        end else begin
            entries_q     <= entries_d;
            count_q       <= count_d;
            iss_valid_q   <= iss_valid_d;
            iss_aluop_q   <= iss_aluop_d;
            iss_src1_q    <= iss_src1_d;
            iss_src2_q    <= iss_src2_d;
            iss_use_imm_q <= iss_use_imm_d;
            iss_imm_q     <= iss_imm_d;
            iss_dest_q    <= iss_dest_d;
            iss_robn_q    <= iss_robn_d;
        end
    end

    assign io.disp_ready  = disp_ready;
    assign io.count       = count_q;
    assign io.iss_valid   = iss_valid_q;
    assign io.iss_aluop   = iss_aluop_q;
    assign io.iss_src1    = iss_src1_q;
    assign io.iss_src2    = iss_src2_q;
    assign io.iss_use_imm = iss_use_imm_q;
    assign io.iss_imm     = iss_imm_q;
    assign io.iss_dest    = iss_dest_q;
    assign io.iss_robn    = iss_robn_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_queue : directed self-checking bench for the ALU IQ     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_issue_queue;
    import alu_iq_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_issue_queue_if #(.NUM_WB(2), .IQ_DEPTH(8)) bus ();

    alu_issue_queue #(.IQ_DEPTH(8), .NUM_WB(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid    = 1'b0;
        bus.disp_src1_rdy = 1'b0;
        bus.disp_src2_rdy = 1'b0;
        bus.disp_use_imm  = 1'b0;
        bus.wb_valid      = '0;
        bus.flush         = 1'b0;
    endtask

    task automatic disp(input logic [TW-1:0] s1, input logic r1, input logic [SIZE-1:0] imm,
                        input logic [TW-1:0] dst, input logic [RW-1:0] robn);
        bus.disp_valid    = 1'b1;
        bus.disp_aluop    = ALU_ADD;
        bus.disp_src1     = s1;
        bus.disp_src1_rdy = r1;
        bus.disp_src2     = '0;
        bus.disp_src2_rdy = 1'b0;
        bus.disp_use_imm  = 1'b1;
        bus.disp_imm      = imm;
        bus.disp_dest     = dst;
        bus.disp_robn     = robn;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        bus.disp_aluop = '0;
        bus.disp_src1  = '0;
        bus.disp_src2  = '0;
        bus.disp_imm   = '0;
        bus.disp_dest  = '0;
        bus.disp_robn  = '0;
        bus.wb_reg     = '0;
        bus.rob_head   = '0;
        bus.fu_ready   = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        check("rst_count", bus.count, 0);
        check("rst_ready", bus.disp_ready, 1);
        check("rst_iss_dest", bus.iss_dest, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_iss_valid", bus.iss_valid, 0);
            check("idle_count", bus.count, 0);
        end

        // Ready dispatch with immediate
        disp(6'd3, 1'b1, 32'd5, 6'd10, 4'd2);
        step();
        idle();
        check("rd_count1", bus.count, 1);
        check("rd_iss_v0", bus.iss_valid, 0);
        step();
        check("rd_iss_v1", bus.iss_valid, 1);
        check("rd_dest", bus.iss_dest, 10);
        check("rd_imm", bus.iss_imm, 5);
        check("rd_use_imm", bus.iss_use_imm, 1);
        check("rd_aluop", bus.iss_aluop, ALU_ADD);
        check("rd_robn", bus.iss_robn, 2);
        check("rd_count0", bus.count, 0);
        step();
        check("rd_iss_v_drop", bus.iss_valid, 0);
        check("rd_dest_hold", bus.iss_dest, 10);

        // Wakeup chain: B depends on A through self-wakeup
        disp(6'd3, 1'b1, 32'd1, 6'd10, 4'd3);
        step();
        check("wc_count_a", bus.count, 1);
        disp(6'd10, 1'b0, 32'd2, 6'd11, 4'd4);
        step();
        idle();
        check("wc_a_valid", bus.iss_valid, 1);
        check("wc_a_dest", bus.iss_dest, 10);
        check("wc_count_b", bus.count, 1);
        step();
        check("wc_b_valid", bus.iss_valid, 1);
        check("wc_b_dest", bus.iss_dest, 11);
        check("wc_count0", bus.count, 0);

        // Entry waiting on tag 20, woken by writeback port 1
        disp(6'd20, 1'b0, 32'd3, 6'd12, 4'd5);
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            step();
            check("wb_wait", bus.iss_valid, 0);
        end
        bus.wb_valid[1] = 1'b1;
        bus.wb_reg[1]   = 6'd20;
        step();
        idle();
        check("wb_edge", bus.iss_valid, 0);
        step();
        check("wb_issue", bus.iss_valid, 1);
        check("wb_dest", bus.iss_dest, 12);

        // Same-cycle wakeup at dispatch via port 0
        disp(6'd21, 1'b0, 32'd4, 6'd13, 4'd6);
        bus.wb_valid[0] = 1'b1;
        bus.wb_reg[0]   = 6'd21;
        step();
        idle();
        check("sw_count", bus.count, 1);
        step();
        check("sw_issue", bus.iss_valid, 1);
        check("sw_dest", bus.iss_dest, 13);

        // Age order across ROB wrap: head=14, robn 15 (age 1) beats robn 1 (age 3)
        bus.rob_head = 4'd14;
        bus.fu_ready = 1'b0;
        disp(6'd1, 1'b1, 32'd0, 6'd30, 4'd1);
        step();
        disp(6'd1, 1'b1, 32'd0, 6'd31, 4'd15);
        step();
        idle();
        check("age_count", bus.count, 2);
        bus.fu_ready = 1'b1;
        step();
        check("age_first", bus.iss_dest, 31);
        check("age_first_robn", bus.iss_robn, 15);
        step();
        check("age_second", bus.iss_dest, 30);
        check("age_second_v", bus.iss_valid, 1);

        // Full / backpressure
        bus.rob_head = 4'd0;
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(6'd1, 1'b1, 32'(i), 6'(40 + i), 4'(i));
            step();
            check("full_count", bus.count, i + 1);
        end
        check("full_ready", bus.disp_ready, 0);
        disp(6'd1, 1'b1, 32'd99, 6'd63, 4'd8);
        step();
        idle();
        check("full_drop_count", bus.count, 8);
        bus.fu_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_valid", bus.iss_valid, 1);
            check("drain_dest", bus.iss_dest, 40 + i);
        end
        step();
        check("drain_done", bus.iss_valid, 0);
        check("drain_count", bus.count, 0);

        // Flush with simultaneous dispatch
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(6'd1, 1'b1, 32'd0, 6'(50 + i), 4'(i));
            step();
        end
        check("fl_count5", bus.count, 5);
        disp(6'd1, 1'b1, 32'd0, 6'd60, 4'd5);
        bus.flush = 1'b1;
        step();
        idle();
        check("fl_count0", bus.count, 0);
        check("fl_iss_v", bus.iss_valid, 0);
        check("fl_ready", bus.disp_ready, 1);
        bus.fu_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_issue", bus.iss_valid, 0);
        end

        // Reset mid-operation clears the issue fields
        disp(6'd1, 1'b1, 32'd7, 6'd33, 4'd9);
        step();
        idle();
        step();
        check("mr_iss_v", bus.iss_valid, 1);
        check("mr_iss_dest", bus.iss_dest, 33);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_rst_v", bus.iss_valid, 0);
        check("mr_rst_dest", bus.iss_dest, 0);
        check("mr_rst_imm", bus.iss_imm, 0);
        check("mr_rst_count", bus.count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
